rx_cp_remove: RTL and testbench
===============================

Name: rx_cp_remove

Overview:
- Receive-chain stage directly upstream of the FFT.
- Accepts a continuous stream of time-domain complex samples over the Wishbone-style handshake. Strips the cyclic prefix from every OFDM symbol and forwards exactly NFFT body samples per symbol to the FFT input.
- CP length is selectable per burst, following the 802.22 options of 1/4, 1/8, 1/16 and 1/32.

Parameters:
- NFFT_LOG2, 11, log2 of the FFT size (2048 for 802.22).
- DW, 32, sample width: Im[31:16], Re[15:0], each in 2.14 format. Data is passed through unmodified.

Ports:
- CLK_I  in  1  single clock.
- RST_I  in  1  asynchronous reset, active-high.
- CP_SEL  in  2  CP length select, latched at burst start: 0 = NFFT/32, 1 = NFFT/16, 2 = NFFT/8, 3 = NFFT/4.
- DAT_I  in  DW  input sample.
- WE_I, STB_I, CYC_I  in  1 each  upstream Wishbone qualifiers.
- ACK_O  out  1  input sample accepted this cycle (combinational).
- DAT_O  out  DW  output sample (registered).
- CYC_O, STB_O  out  1 each  downstream Wishbone qualifiers (registered).
- WE_O  out  1  equal to STB_O.
- ACK_I  in  1  downstream accepted DAT_O.
- SYM_CNT  out  8  number of complete symbols forwarded in the current burst; wraps at 255.

Behaviour:
- Reset values: DAT_O = 0, STB_O = 0, CYC_O = 0, SYM_CNT = 0, state = IDLE, counters = 0, latched CP length = NFFT/32.
- Input transfer: occurs when `in_xfer = CYC_I & STB_I & WE_I & ACK_O`.
- ACK_O in CP state: equals CYC_I. Discarded samples never stall.
- ACK_O in BODY state: equals `CYC_I & ~(STB_O & ~ACK_I)`, i.e. the output register is free or draining this cycle.
- ACK_O in IDLE: 0.
- State machine:
  - IDLE -> CP when CYC_I = 1. On this transition, latch CP_SEL into cp_len, clear the sample counter and clear SYM_CNT.
  - CP: each in_xfer increments the counter. When counter = cp_len-1 on an in_xfer, go to BODY and clear the counter.
  - BODY: each in_xfer loads DAT_I into DAT_O, sets STB_O and increments the counter. When counter = NFFT-1 on an in_xfer, go to CP, clear the counter and increment SYM_CNT.
  - Any state, CYC_I = 0: go to IDLE. A partial symbol is abandoned with no padding and SYM_CNT is unchanged. Data already in DAT_O and STB_O still completes its handshake.
- CP_SEL changes mid-burst are ignored until the next IDLE -> CP transition.
- Output register: STB_O is cleared on ACK_I when no new body sample is loaded that cycle. A simultaneous ACK_I and new load keeps STB_O = 1 with the new data, giving full throughput of 1 sample per clock.
- Latency: body sample accepted at edge k appears on DAT_O/STB_O after edge k.
- CYC_O:
  - Set on the cycle after the first body load of a burst.
  - Cleared when state = IDLE, CYC_I = 0 and STB_O = 0, i.e. after the final ACK_I.
  - Stays high across CP gaps within a burst, so the FFT sees one continuous burst.
- Counter width: NFFT_LOG2 bits. cp_len is held as a NFFT_LOG2-bit value, NFFT >> (5 - CP_SEL).
- Reset mid-burst: all state returns immediately to reset values, including STB_O, with no completion of the pending output.

Decomposition:
- Shared rx package:
  - CP_SEL encoding constants (CP_1_32 = 0, CP_1_16 = 1, CP_1_8 = 2, CP_1_4 = 3).
  - State enum {IDLE, CP, BODY}.
  - Sample field slice positions.
- No sub-module needed. The 3-state FSM, counter and output register fit in one module.

Test Plan:
1. CP_SEL = 0, NFFT = 2048, 3 symbols of ramp data (value = index), ACK_I = 1 throughout:
   - Output is exactly 3×2048 samples: indices 64..2111, 2176..4223, 4288..6335.
   - SYM_CNT = 3. CYC_O falls 1 cycle after the last STB_O.
2. CP_SEL = 3, single symbol: first output sample is input index 512. ACK_O stays high during the CP while ACK_I = 0.
3. Backpressure in BODY:
   - ACK_I toggles 1/0 every cycle.
   - ACK_O = 0 exactly in cycles where STB_O = 1 and ACK_I = 0.
   - No samples are lost or duplicated (compare against a reference model).
4. CYC_I drops after 1000 body samples of symbol 2:
   - 1000 samples are output, then the FSM returns to IDLE and SYM_CNT = 1.
   - A new burst with CP_SEL = 1 discards 128 samples before forwarding.
5. CP_SEL changed from 0 to 3 mid-burst: the CP stays at 64 for the rest of the burst. The next burst uses 512.
6. RST_I asserted asynchronously mid-BODY with STB_O = 1: DAT_O, STB_O, CYC_O and SYM_CNT read 0 before the next clock edge.

Source files
------------

// File: rtl/rx_cp_remove_pkg.sv
// Shared definitions for the receive-side cyclic-prefix removal stage:
// CP length select codes, FSM states and complex sample field positions.
package rx_cp_remove_pkg;

  localparam logic [1:0] CP_1_32 = 2'd0;
  localparam logic [1:0] CP_1_16 = 2'd1;
  localparam logic [1:0] CP_1_8  = 2'd2;
  localparam logic [1:0] CP_1_4  = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CP   = 2'd1,
    BODY = 2'd2
  } rx_state_e;

  // Sample layout: Im in the upper half, Re in the lower half, both 2.14.
  localparam int RE_LSB = 0;
  localparam int RE_MSB = 15;
  localparam int IM_LSB = 16;
  localparam int IM_MSB = 31;

endpackage

// File: rtl/rx_cp_remove.sv
// Cyclic-prefix removal ahead of the FFT: drops cp_len samples per symbol and
// forwards NFFT body samples through a single registered Wishbone-style output.
module rx_cp_remove
  import rx_cp_remove_pkg::*;
#(
  parameter int NFFT_LOG2 = 11,
  parameter int DW        = 32
) (
  input  logic          CLK_I,
  input  logic          RST_I,
  input  logic [1:0]    CP_SEL,
  input  logic [DW-1:0] DAT_I,
  input  logic          WE_I,
  input  logic          STB_I,
  input  logic          CYC_I,
  output logic          ACK_O,
  output logic [DW-1:0] DAT_O,
  output logic          CYC_O,
  output logic          STB_O,
  output logic          WE_O,
  input  logic          ACK_I,
  output logic [7:0]    SYM_CNT,
  output rx_state_e     o_dbg_state
);

  localparam logic [NFFT_LOG2-1:0] ONE      = {{(NFFT_LOG2-1){1'b0}}, 1'b1};
  localparam logic [NFFT_LOG2-1:0] CP_BASE  = ONE << (NFFT_LOG2 - 5);
  localparam logic [NFFT_LOG2-1:0] CNT_LAST = '1;

  // Handshake: an input sample moves when CYC_I & STB_I & WE_I & ACK_O; an
  // output sample moves when STB_O & ACK_I. ACK_O never depends on STB_I.
  rx_state_e            r_state;
  rx_state_e            w_state_nxt;
  logic [NFFT_LOG2-1:0] r_cnt;
  logic [NFFT_LOG2-1:0] r_cp_len;
  logic [7:0]           r_sym_cnt;
  logic [DW-1:0]        r_dat;
  logic                 r_stb;
  logic                 r_cyc;
  logic                 w_ack;
  logic                 w_in_xfer;
  logic                 w_start;
  logic                 w_cp_done;
  logic                 w_load;
  logic                 w_sym_done;

  always_comb begin
    w_ack = 1'b0;
    case (r_state)
      CP:      w_ack = CYC_I;
      BODY:    w_ack = CYC_I & ~(r_stb & ~ACK_I);
      default: w_ack = 1'b0;
    endcase
  end

  assign w_in_xfer  = CYC_I & STB_I & WE_I & w_ack;
  assign w_start    = (r_state == IDLE) & CYC_I;
  assign w_cp_done  = (r_state == CP) & w_in_xfer & (r_cnt == (r_cp_len - ONE));
  assign w_load     = (r_state == BODY) & w_in_xfer;
  assign w_sym_done = w_load & (r_cnt == CNT_LAST);

  always_comb begin
    w_state_nxt = r_state;
    if (!CYC_I) begin
      w_state_nxt = IDLE;
    end else begin
      case (r_state)
        IDLE:    w_state_nxt = CP;
        CP:      if (w_cp_done)  w_state_nxt = BODY;
        BODY:    if (w_sym_done) w_state_nxt = CP;
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // CP length is only sampled at burst start; mid-burst CP_SEL changes are ignored.
  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      r_cnt     <= '0;
      r_cp_len  <= CP_BASE;
      r_sym_cnt <= '0;
    end else if (w_start) begin
      r_cnt     <= '0;
      r_cp_len  <= CP_BASE << CP_SEL;
      r_sym_cnt <= '0;
    end else if (w_cp_done || w_sym_done) begin
      r_cnt <= '0;
      if (w_sym_done) r_sym_cnt <= r_sym_cnt + 8'd1;
    end else if (w_in_xfer) begin
      r_cnt <= r_cnt + ONE;
    end
  end

  // CYC_O spans the whole burst, CP gaps included, and drops only once drained.
  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      r_dat <= '0;
      r_stb <= 1'b0;
      r_cyc <= 1'b0;
    end else begin
      if (w_load) begin
        r_dat <= DAT_I;
        r_stb <= 1'b1;
      end else if (ACK_I) begin
        r_stb <= 1'b0;
      end
      if (w_load)                                     r_cyc <= 1'b1;
      else if ((r_state == IDLE) && !CYC_I && !r_stb) r_cyc <= 1'b0;
    end
  end

  assign ACK_O       = w_ack;
  assign DAT_O       = r_dat;
  assign STB_O       = r_stb;
  assign WE_O        = r_stb;
  assign CYC_O       = r_cyc;
  assign SYM_CNT     = r_sym_cnt;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_rx_cp_remove.sv
// Bench for rx_cp_remove: table of bursts with hand-computed CP lengths and
// symbol counts, per-cycle handshake model, and a reset-mid-body sequence.
module tb_rx_cp_remove;
  import rx_cp_remove_pkg::*;

  localparam int NFFT = 2048;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [1:0]  cp_sel = 2'd0;
  logic [31:0] dat_i  = '0;
  logic        we_i   = 1'b0;
  logic        stb_i  = 1'b0;
  logic        cyc_i  = 1'b0;
  logic        ack_i  = 1'b1;
  logic        ack_o;
  logic [31:0] dat_o;
  logic        cyc_o;
  logic        stb_o;
  logic        we_o;
  logic [7:0]  sym_cnt;
  rx_state_e   dbg_state;

  rx_cp_remove #(.NFFT_LOG2(11), .DW(32)) dut (
    .CLK_I(clk), .RST_I(rst), .CP_SEL(cp_sel), .DAT_I(dat_i),
    .WE_I(we_i), .STB_I(stb_i), .CYC_I(cyc_i), .ACK_O(ack_o),
    .DAT_O(dat_o), .CYC_O(cyc_o), .STB_O(stb_o), .WE_O(we_o),
    .ACK_I(ack_i), .SYM_CNT(sym_cnt), .o_dbg_state(dbg_state)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 30) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] samp(input int tag, input int i);
    logic [15:0] im;
    logic [15:0] re;
    im = 16'(i * 3 + tag * 4369);
    re = 16'(i);
    return {im, re};
  endfunction

  // ---------------- scoreboard + handshake model ----------------
  logic [31:0] exp_q[$];
  bit mon_en = 1'b0;
  int cur_cp = 64;
  bit m_in_burst, m_stb, m_cyc;
  int m_pos, m_sym, m_cp;
  bit nx_in_burst, nx_stb, nx_cyc;
  int nx_pos, nx_sym, nx_cp;

  task automatic model_reset();
    m_in_burst = 0; m_stb = 0; m_cyc = 0; m_pos = 0; m_sym = 0; m_cp = 64;
    nx_in_burst = 0; nx_stb = 0; nx_cyc = 0; nx_pos = 0; nx_sym = 0; nx_cp = 64;
  endtask

  always @(negedge clk) begin
    if (mon_en && !rst) begin
      int  p;
      bit  in_cp, e_ack, xfer, load;
      p     = m_pos % (m_cp + NFFT);
      in_cp = (p < m_cp);
      if (!m_in_burst) e_ack = 1'b0;
      else if (in_cp)  e_ack = cyc_i;
      else             e_ack = cyc_i & ~(m_stb & ~ack_i);
      check("ack_o", {31'b0, ack_o}, {31'b0, e_ack});
      check("stb_o", {31'b0, stb_o}, {31'b0, m_stb});
      check("we_o", {31'b0, we_o}, {31'b0, m_stb});
      check("cyc_o", {31'b0, cyc_o}, {31'b0, m_cyc});
      check("sym_cnt", {24'b0, sym_cnt}, 32'(m_sym));
      if (stb_o && ack_i) begin
        if (exp_q.size() == 0) check("dat_o_unexpected", dat_o, 32'hxxxx_xxxx);
        else                   check("dat_o", dat_o, exp_q.pop_front());
      end
      xfer = cyc_i & stb_i & we_i & e_ack;
      load = 1'b0;
      nx_in_burst = m_in_burst; nx_pos = m_pos; nx_sym = m_sym; nx_cp = m_cp;
      if (!m_in_burst) begin
        if (cyc_i) begin
          nx_in_burst = 1'b1; nx_pos = 0; nx_sym = 0; nx_cp = cur_cp;
        end
      end else if (!cyc_i) begin
        nx_in_burst = 1'b0;
      end else if (xfer) begin
        nx_pos = m_pos + 1;
        load   = !in_cp;
        if (p == m_cp + NFFT - 1) nx_sym = (m_sym + 1) % 256;
      end
      nx_stb = load ? 1'b1 : (ack_i ? 1'b0 : m_stb);
      if (load) nx_cyc = 1'b1;
      else if (!m_in_burst && !cyc_i && !m_stb) nx_cyc = 1'b0;
      else nx_cyc = m_cyc;
    end
  end

  always @(posedge clk) begin
    if (mon_en && !rst) begin
      m_in_burst = nx_in_burst; m_pos = nx_pos; m_sym = nx_sym; m_cp = nx_cp;
      m_stb = nx_stb; m_cyc = nx_cyc;
    end
  end

  // ---------------- driver tasks ----------------
  // ack modes: 0 = always ready, 1 = toggle each cycle, 2 = stalled during CP
  task automatic drive_until(input int target, input int mode, input int tag,
                             input int chg_at, input logic [1:0] chg_sel);
    bit done;
    done = 1'b0;
    for (int c = 0; c < target * 3 + 200; c++) begin
      @(posedge clk); #1;
      if (m_pos >= target) begin
        done = 1'b1;
        break;
      end
      dat_i = samp(tag, m_pos);
      case (mode)
        1:       ack_i = ~ack_i;
        2:       ack_i = ((m_pos % (m_cp + NFFT)) >= m_cp);
        default: ack_i = 1'b1;
      endcase
      if (chg_at >= 0 && m_pos >= chg_at) cp_sel = chg_sel;
    end
    check("drive_done", {31'b0, done}, 32'd1);
  endtask

  task automatic drain();
    for (int c = 0; c < 50; c++) begin
      @(posedge clk); #1;
      if (!cyc_o) break;
    end
    check("cyc_o_drop", {31'b0, cyc_o}, 32'd0);
  endtask

  typedef struct {
    logic [1:0] sel;
    int         n_in;
    int         ack_mode;
    int         chg_at;
    logic [1:0] chg_sel;
    int         exp_cp;
    int         exp_syms;
  } vec_t;

  vec_t vecs[7];

  task automatic run_burst(input int idx);
    vec_t v;
    v = vecs[idx];
    cur_cp = v.exp_cp;
    for (int j = 0; j < v.n_in; j++)
      if ((j % (v.exp_cp + NFFT)) >= v.exp_cp) exp_q.push_back(samp(idx, j));
    cp_sel = v.sel;
    dat_i  = samp(idx, 0);
    ack_i  = 1'b1;
    stb_i  = 1'b1;
    we_i   = 1'b1;
    cyc_i  = 1'b1;
    drive_until(v.n_in, v.ack_mode, idx, v.chg_at, v.chg_sel);
    cyc_i = 1'b0;
    stb_i = 1'b0;
    we_i  = 1'b0;
    ack_i = 1'b1;
    drain();
    check("outputs_all_seen", 32'(exp_q.size()), 32'd0);
    check("burst_sym_cnt", {24'b0, sym_cnt}, 32'(v.exp_syms));
    check("burst_idle", 32'(dbg_state), 32'(IDLE));
    exp_q.delete();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    vecs[0] = '{2'd0, 6336, 0, -1, 2'd0,  64, 3};  // 3 symbols, CP 1/32
    vecs[1] = '{2'd3, 2860, 2, -1, 2'd0, 512, 1};  // CP 1/4, stalled sink during CP
    vecs[2] = '{2'd2, 4608, 1, -1, 2'd0, 256, 2};  // toggling backpressure
    vecs[3] = '{2'd0, 3176, 0, -1, 2'd0,  64, 1};  // abort after 1000 body of symbol 2
    vecs[4] = '{2'd1, 2176, 0, -1, 2'd0, 128, 1};  // new burst, CP 1/16
    vecs[5] = '{2'd0, 4224, 1, 100, 2'd3, 64, 2};  // CP_SEL change mid-burst ignored
    vecs[6] = '{2'd3, 2560, 0, -1, 2'd0, 512, 1};  // next burst picks up 1/4

    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_dat_o", dat_o, 32'd0);
    check("rst_stb_o", {31'b0, stb_o}, 32'd0);
    check("rst_cyc_o", {31'b0, cyc_o}, 32'd0);
    check("rst_sym_cnt", {24'b0, sym_cnt}, 32'd0);
    check("rst_ack_o", {31'b0, ack_o}, 32'd0);
    check("rst_state", 32'(dbg_state), 32'(IDLE));
    rst = 1'b0;
    mon_en = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 7; i++) run_burst(i);

    // Asynchronous reset while a body sample is stalled in the output register.
    cur_cp = 64;
    cp_sel = 2'd0;
    dat_i  = samp(9, 0);
    ack_i  = 1'b0;
    stb_i  = 1'b1;
    we_i   = 1'b1;
    cyc_i  = 1'b1;
    drive_until(65, 3, 9, -1, 2'd0);
    ack_i = 1'b0;
    for (int c = 0; c < 65 * 3 + 200 && m_pos < 65; c++) begin
      @(posedge clk); #1;
      dat_i = samp(9, m_pos);
      ack_i = 1'b0;
    end
    check("pre_rst_stb_o", {31'b0, stb_o}, 32'd1);
    check("pre_rst_dat_o", dat_o, samp(9, 64));
    check("pre_rst_state", 32'(dbg_state), 32'(BODY));
    mon_en = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("async_rst_dat_o", dat_o, 32'd0);
    check("async_rst_stb_o", {31'b0, stb_o}, 32'd0);
    check("async_rst_cyc_o", {31'b0, cyc_o}, 32'd0);
    check("async_rst_sym_cnt", {24'b0, sym_cnt}, 32'd0);
    check("async_rst_state", 32'(dbg_state), 32'(IDLE));
    cyc_i = 1'b0;
    stb_i = 1'b0;
    we_i  = 1'b0;
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("post_rst_stb_o", {31'b0, stb_o}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, %0d checks so far", n_checks);
    $fatal(1, "watchdog");
  end

endmodule
